// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LEGv8 instruction-fetch stage: PC, IF/ID register, redirect/squash, fault.
// Optional end-of-program halt detection is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_stage #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    output logic [5:0]   imem_addr,
    input  logic [31:0]  imem_q,
    output logic [N-1:0] pc_F,
    output logic [31:0]  instr_D,
    output logic [N-1:0] pc_D,
    output logic         valid_D,
    output logic         halted,
    output logic         fault,
    output logic [31:0]  fetch_cnt
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HALTED = 2'd1,
        S_FAULT  = 2'd2
    } state_t;

    localparam logic [31:0] HALT_WORD = 32'hB400001F;
    localparam logic [N-1:0] LAST_PC  = N'(252);

    state_t state;
    state_t state_next;

    logic target_bad;
    logic last_word;
    logic halt_word;
    logic run_go;
    logic do_redirect;
    logic do_fetch;

    assign imem_addr = pc_F[7:2];

    // Only the 64-word ROM (byte addresses 0..255, word aligned) is fetchable.
    assign target_bad = (branch_target[1:0] != 2'b00) || (branch_target[N-1:8] != '0);
    assign last_word  = (pc_F == LAST_PC);

`ifdef FETCH_HALT_DETECT_EN
    assign halt_word = (imem_q == HALT_WORD);
`else
    assign halt_word = 1'b0;
`endif

    assign run_go      = (state == S_RUN) && !stall;
    assign do_redirect = run_go && branch_taken && !target_bad;
    assign do_fetch    = run_go && !branch_taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RUN: begin
                if (!stall) begin
                    if (branch_taken) begin
                        if (target_bad) begin
                            state_next = S_FAULT;
                        end
                    end else if (last_word) begin
                        state_next = S_FAULT;
                    end else if (halt_word) begin
                        state_next = S_HALTED;
                    end
                end
            end
            S_HALTED: state_next = S_HALTED;
            S_FAULT:  state_next = S_FAULT;
            default:  state_next = S_FAULT;
        endcase
    end

    always_comb begin
        fault = (state == S_FAULT);
`ifdef FETCH_HALT_DETECT_EN
        halted = (state == S_HALTED);
`else
        halted = 1'b0;
`endif
    end

    // pc_F holds on the delivering edge of the last ROM word or a halt word,
    // so it stays frozen at the PC that caused the state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_F      <= '0;
            instr_D   <= '0;
            pc_D      <= '0;
            valid_D   <= 1'b0;
            fetch_cnt <= '0;
        end else if (state != S_RUN) begin
            valid_D <= 1'b0;
            if (state == S_FAULT) begin
                instr_D <= '0;
            end
        end else if (!stall) begin
            if (branch_taken) begin
                if (do_redirect) begin
                    pc_F <= branch_target;
                end
                instr_D <= '0;
                valid_D <= 1'b0;
            end else if (do_fetch) begin
                instr_D <= imem_q;
                pc_D    <= pc_F;
                valid_D <= 1'b1;
                if (fetch_cnt != 32'hFFFF_FFFF) begin
                    fetch_cnt <= fetch_cnt + 32'd1;
                end
                if (!last_word && !halt_word) begin
                    pc_F <= pc_F + N'(4);
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage with a behavioural 64-word ROM.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [5:0]  imem_addr;
    logic [31:0] imem_q;
    logic [63:0] pc_F;
    logic [31:0] instr_D;
    logic [63:0] pc_D;
    logic        valid_D;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_cnt;

    logic [31:0] rom [64];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_q = rom[imem_addr];

    fetch_stage #(.N(64)) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .imem_addr(imem_addr),
        .imem_q(imem_q),
        .pc_F(pc_F),
        .instr_D(instr_D),
        .pc_D(pc_D),
        .valid_D(valid_D),
        .halted(halted),
        .fault(fault),
        .fetch_cnt(fetch_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 | (32'(i) << 4) | 32'h5;
        rom[15] = 32'hB400001F;

        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        step(); step();
        check("rst_pc_F", pc_F, 64'd0);
        check("rst_instr_D", instr_D, 64'd0);
        check("rst_pc_D", pc_D, 64'd0);
        check("rst_valid_D", valid_D, 64'd0);
        check("rst_halted", halted, 64'd0);
        check("rst_fault", fault, 64'd0);
        check("rst_fetch_cnt", fetch_cnt, 64'd0);
        check("rst_imem_addr", imem_addr, 64'd0);

        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            check("seq_pc_F", pc_F, 64'(4 * (k + 1)));
            check("seq_pc_D", pc_D, 64'(4 * k));
            check("seq_instr_D", instr_D, 64'(rom[k]));
            check("seq_valid_D", valid_D, 64'd1);
            check("seq_fetch_cnt", fetch_cnt, 64'(k + 1));
        end
        check("seq_imem_addr", imem_addr, 64'd2);

        // Stall with a simultaneous branch request: everything holds.
        stall = 1'b1; branch_taken = 1'b1; branch_target = 64'd40;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_pc_F", pc_F, 64'd8);
            check("stall_pc_D", pc_D, 64'd4);
            check("stall_instr_D", instr_D, 64'(rom[1]));
            check("stall_fetch_cnt", fetch_cnt, 64'd2);
        end
        stall = 1'b0; branch_taken = 1'b0;
        step();
        check("resume_pc_D", pc_D, 64'd8);
        check("resume_instr_D", instr_D, 64'(rom[2]));
        check("resume_pc_F", pc_F, 64'd12);
        check("resume_fetch_cnt", fetch_cnt, 64'd3);

        branch_taken = 1'b1; branch_target = 64'd40;
        step();
        branch_taken = 1'b0;
        check("br_valid_D", valid_D, 64'd0);
        check("br_pc_F", pc_F, 64'd40);
        check("br_instr_D", instr_D, 64'd0);
        check("br_fetch_cnt", fetch_cnt, 64'd3);
        step();
        check("br_tgt_instr_D", instr_D, 64'(rom[10]));
        check("br_tgt_pc_D", pc_D, 64'd40);
        check("br_tgt_valid_D", valid_D, 64'd1);
        check("br_tgt_pc_F", pc_F, 64'd44);
        check("br_tgt_fetch_cnt", fetch_cnt, 64'd4);

        branch_taken = 1'b1; branch_target = 64'd42;
        step();
        check("misal_fault", fault, 64'd1);
        check("misal_valid_D", valid_D, 64'd0);
        check("misal_pc_F", pc_F, 64'd44);
        branch_target = 64'd40;
        step();
        check("fault_hold_pc_F", pc_F, 64'd44);
        check("fault_hold_fault", fault, 64'd1);
        check("fault_hold_valid_D", valid_D, 64'd0);
        check("fault_hold_instr_D", instr_D, 64'd0);
        check("fault_hold_fetch_cnt", fetch_cnt, 64'd4);
        branch_taken = 1'b0;

        // Asynchronous reset takes effect before the next clock edge.
        reset = 1'b1;
        #2;
        check("arst_pc_F", pc_F, 64'd0);
        check("arst_fault", fault, 64'd0);
        check("arst_fetch_cnt", fetch_cnt, 64'd0);
        check("arst_valid_D", valid_D, 64'd0);
        check("arst_pc_D", pc_D, 64'd0);
        check("arst_instr_D", instr_D, 64'd0);
        step();
        reset = 1'b0;

        branch_taken = 1'b1; branch_target = 64'd256;
        step();
        branch_taken = 1'b0;
        check("oob_fault", fault, 64'd1);
        check("oob_pc_F", pc_F, 64'd0);
        check("oob_valid_D", valid_D, 64'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;

        branch_taken = 1'b1; branch_target = 64'd64;
        step();
        branch_taken = 1'b0;
        check("wrap_start_pc_F", pc_F, 64'd64);
        check("wrap_start_valid_D", valid_D, 64'd0);
        for (int k = 0; k < 47; k++) begin
            step();
            check("lin_pc_D", pc_D, 64'(64 + 4 * k));
            check("lin_instr_D", instr_D, 64'(rom[16 + k]));
        end
        check("lin_end_pc_F", pc_F, 64'd252);
        check("lin_end_fault", fault, 64'd0);
        step();
        check("last_pc_D", pc_D, 64'd252);
        check("last_instr_D", instr_D, 64'(rom[63]));
        check("last_valid_D", valid_D, 64'd1);
        check("last_fault", fault, 64'd1);
        check("last_pc_F", pc_F, 64'd252);
        check("last_fetch_cnt", fetch_cnt, 64'd48);
        step();
        check("wrap_valid_D", valid_D, 64'd0);
        check("wrap_fault", fault, 64'd1);
        check("wrap_pc_F", pc_F, 64'd252);
        check("wrap_instr_D", instr_D, 64'd0);

        reset = 1'b1;
        step();
        reset = 1'b0;
        branch_taken = 1'b1; branch_target = 64'd56;
        step();
        branch_taken = 1'b0;
        check("halt_pre_pc_F", pc_F, 64'd56);
        step();
        check("halt_pre_pc_D", pc_D, 64'd56);
        step();
        check("halt_word_pc_D", pc_D, 64'd60);
        check("halt_word_instr_D", instr_D, 64'h0000_0000_B400_001F);
        check("halt_word_valid_D", valid_D, 64'd1);
        check("halt_word_fetch_cnt", fetch_cnt, 64'd2);
`ifdef FETCH_HALT_DETECT_EN
        check("halt_halted", halted, 64'd1);
        check("halt_pc_F", pc_F, 64'd60);
        branch_taken = 1'b1; branch_target = 64'd0;
        for (int k = 0; k < 2; k++) begin
            step();
            check("halted_valid_D", valid_D, 64'd0);
            check("halted_pc_F", pc_F, 64'd60);
            check("halted_halted", halted, 64'd1);
            check("halted_fetch_cnt", fetch_cnt, 64'd2);
        end
        branch_taken = 1'b0;
`else
        check("nohalt_halted", halted, 64'd0);
        check("nohalt_pc_F", pc_F, 64'd64);
        branch_taken = 1'b1; branch_target = 64'd60;
        step();
        branch_taken = 1'b0;
        check("nohalt_br_valid_D", valid_D, 64'd0);
        check("nohalt_br_pc_F", pc_F, 64'd60);
        step();
        check("nohalt_rep_pc_D", pc_D, 64'd60);
        check("nohalt_rep_instr_D", instr_D, 64'h0000_0000_B400_001F);
        check("nohalt_rep_valid_D", valid_D, 64'd1);
        check("nohalt_rep_halted", halted, 64'd0);
        check("nohalt_rep_fetch_cnt", fetch_cnt, 64'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
